// File: rtl/sobel_filter.sv
// Three-lane (R/G/B) 3x3 Sobel magnitude engine: collects nine lockstep samples,
// computes min(|Gx|+|Gy|, 255) per lane and hands each result off independently.
module sobel_filter (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_r_vld,
    input  logic       i_g_vld,
    input  logic       i_b_vld,
    input  logic [7:0] i_r_data,
    input  logic [7:0] i_g_data,
    input  logic [7:0] i_b_data,
    output logic       i_r_busy,
    output logic       i_g_busy,
    output logic       i_b_busy,
    output logic       o_result_r_vld,
    output logic       o_result_g_vld,
    output logic       o_result_b_vld,
    output logic [7:0] o_result_r_data,
    output logic [7:0] o_result_g_data,
    output logic [7:0] o_result_b_data,
    input  logic       o_result_r_busy,
    input  logic       o_result_g_busy,
    input  logic       o_result_b_busy,
    output logic [1:0] o_dbg_state,
    output logic [3:0] o_dbg_cnt
);

    // Handshake: a sample/result moves only at a rising edge where vld=1 and busy=0.
    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [2:0][8:0][7:0]  win_q, win_d;
    logic [2:0][7:0]       mag_q, mag_d;
    logic                  loaded_q, loaded_d;
    logic [2:0]            res_vld_q, res_vld_d;
    logic [2:0][7:0]       res_data_q, res_data_d;
    logic                  busy_q, busy_d;

    logic [2:0]            in_vld;
    logic [2:0][7:0]       in_data;
    logic [2:0]            out_busy;
    logic                  consume;
    logic [2:0]            xfer;

    // Lane index 0 = R, 1 = G, 2 = B.
    assign in_vld   = {i_b_vld, i_g_vld, i_r_vld};
    assign in_data  = {i_b_data, i_g_data, i_r_data};
    assign out_busy = {o_result_b_busy, o_result_g_busy, o_result_r_busy};

    assign consume  = (state_q == ST_COLLECT) && !busy_q && (&in_vld);
    assign xfer     = res_vld_q & ~out_busy;

    // Gradients fit 11-bit two's complement since |Gx|,|Gy| <= 1020.
    function automatic logic [7:0] sobel_mag(input logic [8:0][7:0] w);
        logic [9:0]  px, nx, py, ny;
        logic [10:0] gx, gy, ax, ay;
        logic [11:0] sum;
        px  = {2'b00, w[2]} + {1'b0, w[5], 1'b0} + {2'b00, w[8]};
        nx  = {2'b00, w[0]} + {1'b0, w[3], 1'b0} + {2'b00, w[6]};
        py  = {2'b00, w[6]} + {1'b0, w[7], 1'b0} + {2'b00, w[8]};
        ny  = {2'b00, w[0]} + {1'b0, w[1], 1'b0} + {2'b00, w[2]};
        gx  = {1'b0, px} - {1'b0, nx};
        gy  = {1'b0, py} - {1'b0, ny};
        ax  = gx[10] ? (11'd0 - gx) : gx;
        ay  = gy[10] ? (11'd0 - gy) : gy;
        sum = {1'b0, ax} + {1'b0, ay};
        return (sum > 12'd255) ? 8'hFF : sum[7:0];
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        win_d      = win_q;
        mag_d      = mag_q;
        loaded_d   = loaded_q;
        res_vld_d  = res_vld_q;
        res_data_d = res_data_q;

        case (state_q)
            ST_COLLECT: begin
                if (consume) begin
                    for (int l = 0; l < 3; l++) begin
                        win_d[l][cnt_q] = in_data[l];
                    end
                    if (cnt_q == 4'd8) begin
                        cnt_d   = 4'd0;
                        state_d = ST_COMPUTE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_COMPUTE: begin
                for (int l = 0; l < 3; l++) begin
                    mag_d[l] = sobel_mag(win_q[l]);
                end
                loaded_d = 1'b0;
                state_d  = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                // First OUTPUT cycle publishes the magnitudes; afterwards lanes drain independently.
                if (!loaded_q) begin
                    res_data_d = mag_q;
                    res_vld_d  = 3'b111;
                    loaded_d   = 1'b1;
                end else begin
                    res_vld_d = res_vld_q & ~xfer;
                    if (res_vld_d == 3'b000) begin
                        state_d = ST_COLLECT;
                    end
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase

        busy_d = (state_d != ST_COLLECT);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= ST_COLLECT;
            cnt_q      <= 4'd0;
            win_q      <= '0;
            mag_q      <= '0;
            loaded_q   <= 1'b0;
            res_vld_q  <= 3'b000;
            res_data_q <= '0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            win_q      <= win_d;
            mag_q      <= mag_d;
            loaded_q   <= loaded_d;
            res_vld_q  <= res_vld_d;
            res_data_q <= res_data_d;
            busy_q     <= busy_d;
        end
    end

    assign i_r_busy        = busy_q;
    assign i_g_busy        = busy_q;
    assign i_b_busy        = busy_q;
    assign o_result_r_vld  = res_vld_q[0];
    assign o_result_g_vld  = res_vld_q[1];
    assign o_result_b_vld  = res_vld_q[2];
    assign o_result_r_data = res_data_q[0];
    assign o_result_g_data = res_data_q[1];
    assign o_result_b_data = res_data_q[2];
    assign o_dbg_state     = state_q;
    assign o_dbg_cnt       = cnt_q;

endmodule

// File: tb/tb_sobel_filter.sv
// Bench for sobel_filter: directed windows plus random traffic, checked every
// cycle against a transaction-level model of the window / latency / handoff rules.
module tb_sobel_filter;

    logic       i_clk;
    logic       i_rst;
    logic       i_r_vld, i_g_vld, i_b_vld;
    logic [7:0] i_r_data, i_g_data, i_b_data;
    logic       i_r_busy, i_g_busy, i_b_busy;
    logic       o_result_r_vld, o_result_g_vld, o_result_b_vld;
    logic [7:0] o_result_r_data, o_result_g_data, o_result_b_data;
    logic       o_result_r_busy, o_result_g_busy, o_result_b_busy;
    logic [1:0] o_dbg_state;
    logic [3:0] o_dbg_cnt;

    sobel_filter dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_r_vld         (i_r_vld),
        .i_g_vld         (i_g_vld),
        .i_b_vld         (i_b_vld),
        .i_r_data        (i_r_data),
        .i_g_data        (i_g_data),
        .i_b_data        (i_b_data),
        .i_r_busy        (i_r_busy),
        .i_g_busy        (i_g_busy),
        .i_b_busy        (i_b_busy),
        .o_result_r_vld  (o_result_r_vld),
        .o_result_g_vld  (o_result_g_vld),
        .o_result_b_vld  (o_result_b_vld),
        .o_result_r_data (o_result_r_data),
        .o_result_g_data (o_result_g_data),
        .o_result_b_data (o_result_b_data),
        .o_result_r_busy (o_result_r_busy),
        .o_result_g_busy (o_result_g_busy),
        .o_result_b_busy (o_result_b_busy),
        .o_dbg_state     (o_dbg_state),
        .o_dbg_cnt       (o_dbg_cnt)
    );

    // ---------------- clock / reset ----------------
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_* hold the outputs the DUT must show after the next rising edge.
    logic       m_busy;
    logic [2:0] m_vld;
    logic [7:0] m_data [3];
    logic [7:0] m_res  [3];
    logic [7:0] m_win  [3][$];
    int         m_cd;
    bit         m_acc;

    function automatic int sobel_ref(input int s[9]);
        int kx[9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
        int ky[9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
        int gx = 0;
        int gy = 0;
        int m;
        for (int i = 0; i < 9; i++) begin
            gx += kx[i] * s[i];
            gy += ky[i] * s[i];
        end
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m > 255) ? 255 : m;
    endfunction

    task automatic model_clear();
        m_busy = 1'b1;
        m_vld  = 3'b000;
        m_cd   = 0;
        for (int l = 0; l < 3; l++) begin
            m_data[l] = 8'd0;
            m_res[l]  = 8'd0;
            m_win[l].delete();
        end
    endtask

    task automatic model_step(input logic rst, input logic [2:0] vld,
                              input logic [7:0] dr, input logic [7:0] dg, input logic [7:0] db,
                              input logic [2:0] ob);
        int s[9];
        m_acc = 1'b0;
        if (!rst) begin
            model_clear();
            return;
        end
        if (!m_busy && (&vld)) begin
            m_win[0].push_back(dr);
            m_win[1].push_back(dg);
            m_win[2].push_back(db);
            m_acc = 1'b1;
        end
        for (int l = 0; l < 3; l++) begin
            if (m_vld[l] && !ob[l]) m_vld[l] = 1'b0;
        end
        if (m_cd > 0) begin
            m_cd--;
            if (m_cd == 0) begin
                m_vld = 3'b111;
                for (int l = 0; l < 3; l++) m_data[l] = m_res[l];
            end
        end
        if (m_win[0].size() == 9) begin
            for (int l = 0; l < 3; l++) begin
                for (int i = 0; i < 9; i++) s[i] = int'(m_win[l][i]);
                m_res[l] = 8'(sobel_ref(s));
                m_win[l].delete();
            end
            m_cd = 2;
        end
        m_busy = (m_cd > 0) || (m_vld != 3'b000);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rst, input logic [2:0] vld,
                         input logic [7:0] dr, input logic [7:0] dg, input logic [7:0] db,
                         input logic [2:0] ob);
        @(negedge i_clk);
        i_rst    = rst;
        i_r_vld  = vld[0];
        i_g_vld  = vld[1];
        i_b_vld  = vld[2];
        i_r_data = dr;
        i_g_data = dg;
        i_b_data = db;
        o_result_r_busy = ob[0];
        o_result_g_busy = ob[1];
        o_result_b_busy = ob[2];
        model_step(rst, vld, dr, dg, db, ob);
    endtask

    task automatic idle(input logic [2:0] ob);
        drive(1'b1, 3'b000, 8'd0, 8'd0, 8'd0, ob);
    endtask

    // Present a triple until the model predicts it is consumed; returns the number of edges used.
    task automatic send_triple(input logic [7:0] dr, input logic [7:0] dg, input logic [7:0] db,
                               input logic [2:0] ob, output int tries);
        tries = 0;
        do begin
            drive(1'b1, 3'b111, dr, dg, db, ob);
            tries++;
        end while (!m_acc && tries < 40);
        if (!m_acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_window(input logic [7:0] r[9], input logic [7:0] g[9],
                               input logic [7:0] b[9], input logic [2:0] ob);
        int t;
        for (int i = 0; i < 9; i++) send_triple(r[i], g[i], b[i], ob, t);
    endtask

    task automatic after_edge();
        @(posedge i_clk);
        #3;
    endtask

    task automatic chk_results(input string tag, input int er, input int eg, input int eb);
        chk({tag, "_vld"}, {o_result_b_vld, o_result_g_vld, o_result_r_vld}, 3'b111);
        chk({tag, "_r"}, o_result_r_data, er);
        chk({tag, "_g"}, o_result_g_data, eg);
        chk({tag, "_b"}, o_result_b_data, eb);
        chk({tag, "_model_r"}, m_data[0], er);
        chk({tag, "_model_g"}, m_data[1], eg);
    endtask

    // ---------------- scoreboard: per-cycle compare ----------------
    always begin
        @(posedge i_clk);
        #2;
        if (chk_en) begin
            chk("busy_r", i_r_busy, m_busy);
            chk("busy_g", i_g_busy, m_busy);
            chk("busy_b", i_b_busy, m_busy);
            chk("res_vld", {o_result_b_vld, o_result_g_vld, o_result_r_vld}, m_vld);
            chk("res_r", o_result_r_data, m_data[0]);
            chk("res_g", o_result_g_data, m_data[1]);
            chk("res_b", o_result_b_data, m_data[2]);
            chk("cnt", o_dbg_cnt, m_win[0].size());
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] wr[9], wg[9], wb[9], wz[9], w100[9];
        int t;

        i_rst = 1'b0;
        {i_r_vld, i_g_vld, i_b_vld} = 3'b000;
        {i_r_data, i_g_data, i_b_data} = '0;
        {o_result_r_busy, o_result_g_busy, o_result_b_busy} = 3'b000;
        model_clear();
        chk_en = 1'b1;

        // reset state
        drive(1'b0, 3'b111, 8'd1, 8'd2, 8'd3, 3'b000);
        drive(1'b0, 3'b111, 8'd1, 8'd2, 8'd3, 3'b000);
        after_edge();
        chk("rst_busy", i_r_busy, 1'b1);
        chk("rst_vld", {o_result_b_vld, o_result_g_vld, o_result_r_vld}, 3'b000);
        chk("rst_data", {o_result_r_data, o_result_g_data, o_result_b_data}, 24'd0);
        idle(3'b000);
        after_edge();
        chk("rel_busy", i_g_busy, 1'b0);

        // uniform window -> zero gradient
        for (int i = 0; i < 9; i++) begin
            w100[i] = 8'd100;
            wz[i]   = 8'd0;
            wr[i]   = 8'd0;
            wg[i]   = (i % 3 == 2) ? 8'd255 : 8'd0;
        end
        wr[2] = 8'd10;
        send_window(w100, w100, w100, 3'b111);
        idle(3'b111);
        idle(3'b111);
        after_edge();
        chk_results("uniform", 0, 0, 0);
        idle(3'b000);

        // single-pixel R, saturating G; R consumer stalled for three cycles
        send_window(wr, wg, wz, 3'b111);
        idle(3'b111);
        idle(3'b111);
        after_edge();
        chk_results("edge", 20, 255, 0);
        idle(3'b001);
        after_edge();
        chk("stall_gb_vld", {o_result_b_vld, o_result_g_vld}, 2'b00);
        chk("stall_r_vld", o_result_r_vld, 1'b1);
        idle(3'b001);
        idle(3'b001);
        after_edge();
        chk("stall_r_hold", o_result_r_data, 8'd20);
        chk("stall_busy", i_b_busy, 1'b1);
        idle(3'b000);
        after_edge();
        chk("stall_done_busy", i_r_busy, 1'b0);

        // G vld gap after four triples: counter holds, result unchanged
        for (int i = 0; i < 4; i++) send_triple(wr[i], wg[i], wz[i], 3'b111, t);
        drive(1'b1, 3'b101, 8'd77, 8'd77, 8'd77, 3'b111);
        after_edge();
        chk("gap_cnt", o_dbg_cnt, 4'd4);
        drive(1'b1, 3'b101, 8'd99, 8'd99, 8'd99, 3'b111);
        for (int i = 4; i < 9; i++) send_triple(wr[i], wg[i], wz[i], 3'b111, t);
        idle(3'b111);
        idle(3'b111);
        after_edge();
        chk_results("gap", 20, 255, 0);
        idle(3'b000);

        // reset mid-window: only the fresh window counts
        for (int i = 0; i < 5; i++) send_triple(8'd255, 8'd255, 8'd255, 3'b111, t);
        drive(1'b0, 3'b000, 8'd0, 8'd0, 8'd0, 3'b111);
        drive(1'b0, 3'b000, 8'd0, 8'd0, 8'd0, 3'b111);
        idle(3'b111);
        wr = wz; wg = wz; wb = wz;
        wr[0] = 8'd50;
        wg[7] = 8'd40;
        wb[4] = 8'd200;
        send_window(wr, wg, wb, 3'b111);
        idle(3'b111);
        idle(3'b111);
        after_edge();
        chk_results("post_rst", 100, 80, 0);
        idle(3'b000);

        // back-to-back windows with free consumer
        for (int i = 0; i < 9; i++) send_triple(8'($urandom), 8'($urandom), 8'($urandom), 3'b000, t);
        send_triple(8'($urandom), 8'($urandom), 8'($urandom), 3'b000, t);
        chk("b2b_gap", t, 4);
        for (int i = 1; i < 9; i++) send_triple(8'($urandom), 8'($urandom), 8'($urandom), 3'b000, t);
        for (int i = 0; i < 4; i++) idle(3'b000);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            logic [2:0] v, ob;
            logic [7:0] d[3];
            logic       rst;
            for (int l = 0; l < 3; l++) begin
                v[l]  = ($urandom_range(0, 7) != 0);
                ob[l] = ($urandom_range(0, 2) == 0);
                case ($urandom_range(0, 3))
                    0:       d[l] = 8'd0;
                    1:       d[l] = 8'd255;
                    default: d[l] = 8'($urandom);
                endcase
            end
            rst = ($urandom_range(0, 199) != 0);
            drive(rst, v, d[0], d[1], d[2], ob);
        end
        for (int i = 0; i < 6; i++) idle(3'b000);

        after_edge();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_filter.md
SOBEL_FILTER -- requirements
Module: SobelFilter

Interface
REQ-001 SHALL have no parameters; all data paths are fixed at 8 bits and the window at 3x3 (9 samples).
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, asynchronous, active-low.
REQ-004 i_r_vld / i_g_vld / i_b_vld  input  1 each  producer has a valid sample on that channel.
REQ-005 i_r_data / i_g_data / i_b_data  input  8 each  unsigned sample for R/G/B channel.
REQ-006 i_r_busy / i_g_busy / i_b_busy  output  1 each  block cannot accept a sample on that channel.
REQ-007 o_result_r_vld / _g_vld / _b_vld  output  1 each  result valid on that channel.
REQ-008 o_result_r_data / _g_data / _b_data  output  8 each  unsigned Sobel magnitude per channel.
REQ-009 o_result_r_busy / _g_busy / _b_busy  input  1 each  consumer cannot accept a result on that channel.

Function
REQ-010 SHALL transfer on any channel only at a rising edge where vld=1 and busy=0 (busy/vld point-to-point handshake).
REQ-011 SHALL treat R, G, B as lockstep lanes: one input triple is consumed only when all three i_*_vld=1 and the block is in COLLECT; otherwise no lane consumes.
REQ-012 SHALL drive all three i_*_busy identically: 0 in COLLECT, 1 in COMPUTE, OUTPUT and during reset.
REQ-013 SHALL run FSM COLLECT -> COMPUTE -> OUTPUT -> COLLECT, with a 4-bit sample counter 0..8.
REQ-014 COLLECT: each consumed triple stores sample s[cnt] per lane, cnt increments; on the consume with cnt=8, cnt wraps to 0 and FSM goes to COMPUTE.
REQ-015 Samples SHALL be taken in window row-major order: s0 s1 s2 / s3 s4 s5 / s6 s7 s8.
REQ-016 COMPUTE (exactly one cycle) SHALL, per lane, compute Gx = (s2+2*s5+s8) - (s0+2*s3+s6) and Gy = (s6+2*s7+s8) - (s0+2*s1+s2) as signed values of at least 11 bits (range -1020..1020), without overflow.
REQ-017 Result per lane SHALL be min(|Gx|+|Gy|, 255), registered into o_result_*_data; FSM then enters OUTPUT with all three o_result_*_vld=1.
REQ-018 Latency: result vld SHALL rise on the second rising edge after the edge consuming s8 (one COMPUTE cycle in between).
REQ-019 OUTPUT: each lane's o_result_*_vld SHALL clear at the edge where that lane transfers (vld=1, busy=0); data SHALL stay stable while vld=1.
REQ-020 Lanes MAY complete in different cycles; FSM SHALL return to COLLECT on the edge where the last pending lane transfers (simultaneous completion of all lanes returns in the same edge).
REQ-021 SHALL not consume any input while any result is still pending.
REQ-022 o_result_*_vld SHALL be 0 in COLLECT and COMPUTE.
REQ-023 Input vld deassertion mid-window SHALL simply stall the counter; partial window is kept.

Reset
REQ-024 While i_rst=0 (asynchronously on assertion): FSM=COLLECT, cnt=0, all o_result_*_vld=0, all o_result_*_data=0, i_*_busy=1, stored samples cleared to 0.
REQ-025 Reset mid-window or mid-output SHALL discard the partial window and any pending result; first triple after release is s0.
REQ-026 i_*_busy SHALL drop to 0 on the first rising edge after i_rst deasserts.

Verification
REQ-027 9 triples all R=G=B=100 -> all three results 0.
REQ-028 R window s2=10, others 0; G window s0..s8 = 0,0,255,0,0,255,0,0,255; B all 0 -> R=20, G=255 (Gx=1020, saturated), B=0.
REQ-029 Hold o_result_r_busy=1 for 3 cycles while G/B busy=0 -> G/B vld clear after one edge, R vld and data held stable 3 cycles then transfer; i_*_busy stays 1 until R transfer edge, then 0.
REQ-030 Drop i_g_vld for 2 cycles after triple 4 -> no lane consumes during gap, cnt holds at 4, final results identical to uninterrupted run.
REQ-031 Assert i_rst after 5 triples, release, send full 9-triple window -> results computed only from the new 9 triples; no spurious result vld.
REQ-032 Two back-to-back windows with busy=0 on outputs -> two result sets, each 2 edges after its s8, 1 idle-busy cycle between them.
